// File: rtl/decode_hazard_scoreboard.sv
// RAW hazard scoreboard: in-order ring of pending rd writes; stall/issue are zero-latency comb, state visible next cycle.
// Backpressure: stall holds decode on a source/pending-rd match or when a writing instruction meets a full ring.
module decode_hazard_scoreboard #(
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_SRC      = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dec_valid,
  input  logic [REG_ADDR_W:0]           dec_rd_id,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] dec_rs_id,
  input  logic [NUM_SRC-1:0]            dec_rs_used,
  output logic                          stall,
  output logic                          issue,
  input  logic                          wb_valid,
  input  logic                          flush,
  input  logic [CNT_W-1:0]              flush_keep,
  output logic [CNT_W-1:0]              count,
  output logic                          full,
  output logic                          empty,
  output logic [2**REG_ADDR_W-1:0]      busy_vec,
  output logic                          err_underflow
);

  localparam int PTR_W    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic [REG_ADDR_W-1:0] rd_q [MAX_INFLIGHT];
  logic [REG_ADDR_W-1:0] rd_d [MAX_INFLIGHT];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  err_q, err_d;

  logic [MAX_INFLIGHT-1:0] ent_vld;
  logic [NUM_REGS-1:0]     busy;
  logic                    hazard, writes, is_full, is_empty, push, pop;
  logic [CNT_W-1:0]        cnt_pop, keep;
  logic [REG_ADDR_W-1:0]   rs;

  // Ring size need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                input logic [CNT_W-1:0] inc);
    int s;
    s = int'(ptr) + int'(inc);
    if (s >= MAX_INFLIGHT) s = s - MAX_INFLIGHT;
    return PTR_W'(s);
  endfunction

  function automatic logic entry_live(input int idx, input logic [PTR_W-1:0] hd,
                                      input logic [CNT_W-1:0] cnt);
    int off;
    off = idx - int'(hd);
    if (off < 0) off = off + MAX_INFLIGHT;
    return off < int'(cnt);
  endfunction

  always_comb begin
    ent_vld = '0;
    busy    = '0;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      ent_vld[i] = entry_live(i, head_q, count_q);
      if (ent_vld[i]) busy[rd_q[i]] = 1'b1;
    end
  end

  // Busy bits come from registered entries only: a same-cycle writeback never unblocks.
  always_comb begin
    hazard = 1'b0;
    rs     = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      rs = dec_rs_id[s*REG_ADDR_W +: REG_ADDR_W];
      if (dec_rs_used[s] && (rs != '0) && busy[rs]) hazard = 1'b1;
    end
  end

  assign writes   = dec_rd_id[REG_ADDR_W] && (dec_rd_id[REG_ADDR_W-1:0] != '0);
  assign is_full  = (count_q == CNT_W'(MAX_INFLIGHT));
  assign is_empty = (count_q == '0);
  assign stall    = dec_valid && (hazard || (writes && is_full));
  assign issue    = dec_valid && !stall && !flush;
  assign push     = issue && writes;
  assign pop      = wb_valid && !is_empty;

  always_comb begin
    rd_d    = rd_q;
    head_d  = pop ? wrap_add(head_q, CNT_W'(1)) : head_q;
    cnt_pop = count_q - CNT_W'(pop);
    keep    = (flush_keep < cnt_pop) ? flush_keep : cnt_pop;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q || (wb_valid && is_empty);
    if (flush) begin
      tail_d  = wrap_add(head_d, keep);
      count_d = keep;
    end else begin
      if (push) begin
        rd_d[tail_q] = dec_rd_id[REG_ADDR_W-1:0];
        tail_d       = wrap_add(tail_q, CNT_W'(1));
      end
      count_d = cnt_pop + CNT_W'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < MAX_INFLIGHT; i++) rd_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  assign count         = count_q;
  assign full          = is_full;
  assign empty         = is_empty;
  assign busy_vec      = busy;
  assign err_underflow = err_q;

endmodule

// File: doc/decode_hazard_scoreboard.md
# decode_hazard_scoreboard

Parametrised read-after-write hazard scoreboard at the decode/execute boundary. It tracks, in program order, the destination registers of issued instructions that have not yet written back. It stalls decode when any source register of the presenting instruction matches a pending destination, or when the tracker is full. It also rewinds its state on a squash after J or JALR, which removes all speculative entries younger than the control transfer.

## Interface
Parameters:
- REG_ADDR_W, 5, register id width; the register file holds 2**REG_ADDR_W registers, and register 0 is hardwired zero.
- NUM_SRC, 2, number of source operand ports (rs1, rs2, ...).
- MAX_INFLIGHT, 4, pending-write entries tracked; must be at least 1.
- CNT_W, $clog2(MAX_INFLIGHT+1), occupancy counter width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- dec_valid  in  1  decode presents an instruction this cycle.
- dec_rd_id  in  REG_ADDR_W+1  destination; MSB is the write enable, low bits are the rd index.
- dec_rs_id  in  NUM_SRC*REG_ADDR_W  source ids packed; source i occupies bits [i*REG_ADDR_W +: REG_ADDR_W].
- dec_rs_used  in  NUM_SRC  source i is actually read.
- stall  out  1  decode must hold the instruction.
- issue  out  1  instruction accepted this cycle.
- wb_valid  in  1  oldest pending write retires.
- flush  in  1  squash after J/JALR.
- flush_keep  in  CNT_W  number of oldest entries that survive the flush.
- count  out  CNT_W  current occupancy.
- full  out  1  count == MAX_INFLIGHT.
- empty  out  1  count == 0.
- busy_vec  out  2**REG_ADDR_W  bit r is set when register r has a pending write.
- err_underflow  out  1  sticky flag: wb_valid arrived while empty.

## Operation
- State: a circular buffer of MAX_INFLIGHT rd indices, plus head and tail pointers and a count. Pointers wrap modulo MAX_INFLIGHT and MAX_INFLIGHT need not be a power of two.
- writes = dec_rd_id MSB AND rd index != 0. Writes to register 0 are never tracked.
- hazard = OR over sources i of: dec_rs_used[i] AND rs_i != 0 AND rs_i matches the rd of any valid entry.
- stall = dec_valid AND (hazard OR (writes AND full)). The full check does not consider a same-cycle wb_valid (conservative).
- issue = dec_valid AND NOT stall AND NOT flush.
- Push: issue AND writes writes rd at tail, advances tail, and increments count.
- Pop: wb_valid AND NOT empty advances head and decrements count.
- Pop with empty: no state change; err_underflow is set and stays set until rst.
- Hazard matching uses registered entries only. A same-cycle wb_valid does not clear a hazard, and there is no bypass.
- Same-cycle push and pop: count unchanged, and both pointers advance.
- Flush ordering:
  - Apply the pop first.
  - Then truncate to keep = min(flush_keep, count after pop).
  - tail = head_after_pop + keep (mod MAX_INFLIGHT); count = keep.
  - issue is forced to 0, so no push happens that cycle.
- busy_vec is an OR-decode of all valid entries. A register that appears in several entries stays busy until its last entry pops.
- rst: head = tail = 0, count = 0, err_underflow = 0. rst overrides all simultaneous inputs.

## Timing
- Reset values: count 0, full 0, empty 1, busy_vec 0, err_underflow 0.
- With dec_valid = 0 after reset, stall = 0 and issue = 0.
- stall and issue are combinational from the inputs and current state, with zero latency.
- State changes are visible one cycle later:
  - An issue at cycle N is visible in count, busy_vec and hazards at N+1.
  - An instruction reading that rd at N+1 stalls.
- A pop at cycle N clears the corresponding busy bit at N+1 if no other entry holds that rd. A dependent instruction issues at N+1 at the earliest.
- count, full, empty and busy_vec are functions of registered state only (no input-to-output path).
- Reset mid-operation: the state is empty in the cycle after rst is sampled high. Pending entries are discarded and no wb is expected for them.

## Test plan
- Basic hazard:
  - Stimulus: issue rd = x5; next cycle present rs1 = x5, used.
  - Required: stall = 1 until wb_valid pops it, then issue = 1 the cycle after the pop.
  - Repeat with rs1 = x5 but dec_rs_used[0] = 0: required issue = 1 at once.
- Register 0:
  - Stimulus: issue rd = x0, then read rs1 = x0.
  - Required: count stays 0 and no stall.
- Full and wrap:
  - Stimulus: MAX_INFLIGHT = 4; issue x1..x4 with no dependencies.
  - Required: full = 1 and a 5th writing instruction stalls.
  - Stimulus: pop one, then issue x6.
  - Required: tail wraps to 0 and busy_vec = {x2, x3, x4, x6}.
- Simultaneous events:
  - Stimulus: count = 2, with wb_valid and an independent issue in the same cycle.
  - Required: count stays 2 and the head entry's busy bit clears.
- Flush:
  - Stimulus: count = 4 (x1..x4), flush with flush_keep = 1 and wb_valid = 1.
  - Required: next cycle count = 1, busy_vec = {x2}, and no issue in the flush cycle.
- Error and reset:
  - Stimulus: wb_valid while empty.
  - Required: err_underflow = 1 and count stays 0.
  - Stimulus: rst with count = 3.
  - Required: next cycle count = 0, empty = 1, err_underflow = 0.
